// File: rtl/stage2_execute_if.sv
// Decode-to-execute and execute-to-writeback signal bundle for stage2_execute.
// The master side drives the instruction inputs. The slave side is the execute stage.
interface stage2_execute_if;
    logic [15:0] pc_in;
    logic [6:0]  op_cc_in;
    logic [15:0] rd_val_in;
    logic [15:0] op2_in;
    logic [3:0]  dest_in;
    logic        valid_in;
    logic        stall_out;
    logic [15:0] pc_out;
    logic [4:0]  op_out;
    logic [3:0]  dest_out;
    logic [15:0] result_out;
    logic [15:0] store_data_out;
    logic        valid_out;
    logic        wb_en_out;
    logic        mem_rd_out;
    logic        mem_wr_out;
    logic        z_out;
    logic        halt_out;

    modport master (
        output pc_in, op_cc_in, rd_val_in, op2_in, dest_in, valid_in,
        input  stall_out, pc_out, op_out, dest_out, result_out, store_data_out,
               valid_out, wb_en_out, mem_rd_out, mem_wr_out, z_out, halt_out
    );

    modport slave (
        input  pc_in, op_cc_in, rd_val_in, op2_in, dest_in, valid_in,
        output stall_out, pc_out, op_out, dest_out, result_out, store_data_out,
               valid_out, wb_en_out, mem_rd_out, mem_wr_out, z_out, halt_out
    );
endinterface

// File: rtl/stage2_execute.sv
// Execute stage: single-cycle ALU, shifter and memory address pass-through.
// Multi-cycle MUL is done as 4-bit shift-add steps while the stage stalls upstream.
module stage2_execute (
    input  logic            clk,
    input  logic            reset,
    stage2_execute_if.slave bus
);
    typedef enum logic [4:0] {
        OP_ADD  = 5'b00000, OP_SUB  = 5'b00001, OP_AND  = 5'b00010, OP_BIC  = 5'b00011,
        OP_EOR  = 5'b00100, OP_ORR  = 5'b00101, OP_MOV  = 5'b00110, OP_NEG  = 5'b00111,
        OP_SLT  = 5'b01000, OP_SHA  = 5'b01001, OP_MUL  = 5'b01010, OP_LDR  = 5'b01011,
        OP_STR  = 5'b01100, OP_NOP  = 5'b01101, OP_SYS  = 5'b01110, OP_ADDF = 5'b01111,
        OP_SUBF = 5'b10000, OP_MULF = 5'b10001, OP_ITOF = 5'b10010, OP_FTOI = 5'b10011,
        OP_RECF = 5'b10100
    } opcode_e;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    localparam logic [1:0] CC_S = 2'd1;

    state_e      state_q, state_d;
    logic [1:0]  count_q, count_d;
    logic [15:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [15:0] mul_pc_q, mul_pc_d;
    logic [3:0]  mul_dest_q, mul_dest_d;
    logic        mul_s_q, mul_s_d;

    logic [15:0] pc_out_q, pc_out_d, result_q, result_d, store_q, store_d;
    logic [4:0]  op_out_q, op_out_d;
    logic [3:0]  dest_out_q, dest_out_d;
    logic        valid_q, valid_d, wb_q, wb_d, mrd_q, mrd_d, mwr_q, mwr_d;
    logic        z_q, z_d, halt_q, halt_d;

    opcode_e     op;
    logic [1:0]  cc;
    logic        accept;
    logic [15:0] neg_amt, sha_res, alu_res, partial, mul_res;
    logic        alu_wb, alu_rd, alu_wr;

    assign op      = opcode_e'(bus.op_cc_in[6:2]);
    assign cc      = bus.op_cc_in[1:0];
    assign accept  = bus.valid_in && (state_q == IDLE) && !halt_q;
    assign partial = mcand_q * {12'd0, mplier_q[3:0]};
    assign mul_res = acc_q + partial;

    always_comb begin
        neg_amt = ~bus.op2_in + 16'd1;
        if (!bus.op2_in[15]) begin
            sha_res = (bus.op2_in > 16'd15) ? '0 : (bus.rd_val_in << bus.op2_in[3:0]);
        end else begin
            sha_res = (neg_amt > 16'd15) ? {16{bus.rd_val_in[15]}}
                                         : $unsigned($signed(bus.rd_val_in) >>> neg_amt[3:0]);
        end
        alu_res = '0;
        alu_wb  = 1'b0;
        alu_rd  = 1'b0;
        alu_wr  = 1'b0;
        case (op)
            OP_ADD: begin alu_res = bus.rd_val_in + bus.op2_in;    alu_wb = 1'b1; end
            OP_SUB: begin alu_res = bus.rd_val_in - bus.op2_in;    alu_wb = 1'b1; end
            OP_AND: begin alu_res = bus.rd_val_in & bus.op2_in;    alu_wb = 1'b1; end
            OP_BIC: begin alu_res = bus.rd_val_in & ~bus.op2_in;   alu_wb = 1'b1; end
            OP_EOR: begin alu_res = bus.rd_val_in ^ bus.op2_in;    alu_wb = 1'b1; end
            OP_ORR: begin alu_res = bus.rd_val_in | bus.op2_in;    alu_wb = 1'b1; end
            OP_MOV: begin alu_res = bus.op2_in;                    alu_wb = 1'b1; end
            OP_NEG: begin alu_res = neg_amt;                       alu_wb = 1'b1; end
            OP_SLT: begin
                alu_res = ($signed(bus.rd_val_in) < $signed(bus.op2_in)) ? 16'd1 : 16'd0;
                alu_wb  = 1'b1;
            end
            OP_SHA: begin alu_res = sha_res;                       alu_wb = 1'b1; end
            OP_LDR: begin alu_res = bus.op2_in; alu_wb = 1'b1;     alu_rd = 1'b1; end
            OP_STR: begin alu_res = bus.op2_in;                    alu_wr = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            mul_pc_q   <= '0;
            mul_dest_q <= '0;
            mul_s_q    <= 1'b0;
            pc_out_q   <= '0;
            op_out_q   <= '0;
            dest_out_q <= '0;
            result_q   <= '0;
            store_q    <= '0;
            valid_q    <= 1'b0;
            wb_q       <= 1'b0;
            mrd_q      <= 1'b0;
            mwr_q      <= 1'b0;
            z_q        <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            mul_pc_q   <= mul_pc_d;
            mul_dest_q <= mul_dest_d;
            mul_s_q    <= mul_s_d;
            pc_out_q   <= pc_out_d;
            op_out_q   <= op_out_d;
            dest_out_q <= dest_out_d;
            result_q   <= result_d;
            store_q    <= store_d;
            valid_q    <= valid_d;
            wb_q       <= wb_d;
            mrd_q      <= mrd_d;
            mwr_q      <= mwr_d;
            z_q        <= z_d;
            halt_q     <= halt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: if (accept && op == OP_MUL) begin
                state_d = BUSY;
                count_d = '0;
            end
            BUSY: begin
                count_d = count_q + 2'd1;
                if (count_q == 2'd3) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        mul_pc_d   = mul_pc_q;
        mul_dest_d = mul_dest_q;
        mul_s_d    = mul_s_q;
        pc_out_d   = '0;
        op_out_d   = '0;
        dest_out_d = '0;
        result_d   = '0;
        store_d    = '0;
        valid_d    = 1'b0;
        wb_d       = 1'b0;
        mrd_d      = 1'b0;
        mwr_d      = 1'b0;
        z_d        = z_q;
        halt_d     = halt_q;
        if (state_q == BUSY) begin
            // Multiplicand moves up one nibble while the multiplier drains its low nibble.
            mcand_d  = mcand_q << 4;
            mplier_d = mplier_q >> 4;
            acc_d    = mul_res;
            if (count_q == 2'd3) begin
                valid_d    = 1'b1;
                wb_d       = 1'b1;
                pc_out_d   = mul_pc_q;
                op_out_d   = OP_MUL;
                dest_out_d = mul_dest_q;
                result_d   = mul_res;
                if (mul_s_q) z_d = (mul_res == 16'd0);
            end
        end else if (accept) begin
            if (op == OP_MUL) begin
                mcand_d    = bus.rd_val_in;
                mplier_d   = bus.op2_in;
                acc_d      = '0;
                mul_pc_d   = bus.pc_in;
                mul_dest_d = bus.dest_in;
                mul_s_d    = (cc == CC_S);
            end else begin
                valid_d    = 1'b1;
                pc_out_d   = bus.pc_in;
                op_out_d   = op;
                dest_out_d = bus.dest_in;
                result_d   = alu_res;
                store_d    = alu_wr ? bus.rd_val_in : '0;
                wb_d       = alu_wb;
                mrd_d      = alu_rd;
                mwr_d      = alu_wr;
                if (cc == CC_S && alu_wb && op != OP_LDR) z_d = (alu_res == 16'd0);
                if (op == OP_SYS) halt_d = 1'b1;
            end
        end
    end

    assign bus.stall_out      = (state_q == BUSY);
    assign bus.pc_out         = pc_out_q;
    assign bus.op_out         = op_out_q;
    assign bus.dest_out       = dest_out_q;
    assign bus.result_out     = result_q;
    assign bus.store_data_out = store_q;
    assign bus.valid_out      = valid_q;
    assign bus.wb_en_out      = wb_q;
    assign bus.mem_rd_out     = mrd_q;
    assign bus.mem_wr_out     = mwr_q;
    assign bus.z_out          = z_q;
    assign bus.halt_out       = halt_q;
endmodule

// File: tb/tb_stage2_execute.sv
// Scoreboard bench for stage2_execute: every accepted instruction queues its expected
// writeback record, and a negedge monitor retires records as valid_out appears.
module tb_stage2_execute;
    localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, AND_ = 5'd2, BIC = 5'd3, EOR = 5'd4,
                           ORR = 5'd5, MOV = 5'd6, NEG = 5'd7, SLT = 5'd8, SHA = 5'd9,
                           MUL = 5'd10, LDR = 5'd11, STR = 5'd12, NOP = 5'd13, SYS = 5'd14,
                           ADDF = 5'd15, RECF = 5'd20;
    localparam logic [1:0] AL = 2'd0, S = 2'd1;

    typedef struct packed {
        logic [15:0] pc;
        logic [4:0]  op;
        logic [3:0]  dest;
        logic [15:0] result;
        logic [15:0] store;
        logic        wb;
        logic        mrd;
        logic        mwr;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] next_pc = 16'h0100;
    exp_t sb[$];
    exp_t act, e;

    stage2_execute_if bus ();

    stage2_execute dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [4:0] op, input logic [15:0] rd,
                                   input logic [15:0] op2, input logic [15:0] pc,
                                   input logic [3:0] dest);
        exp_t r;
        int sh;
        logic [31:0] prod;
        r = '0;
        r.pc = pc;
        r.op = op;
        r.dest = dest;
        case (op)
            ADD:  begin r.result = rd + op2;  r.wb = 1'b1; end
            SUB:  begin r.result = rd - op2;  r.wb = 1'b1; end
            AND_: begin r.result = rd & op2;  r.wb = 1'b1; end
            BIC:  begin r.result = rd & ~op2; r.wb = 1'b1; end
            EOR:  begin r.result = rd ^ op2;  r.wb = 1'b1; end
            ORR:  begin r.result = rd | op2;  r.wb = 1'b1; end
            MOV:  begin r.result = op2;       r.wb = 1'b1; end
            NEG:  begin r.result = 16'd0 - op2; r.wb = 1'b1; end
            SLT:  begin r.result = (int'($signed(rd)) < int'($signed(op2))) ? 16'd1 : 16'd0; r.wb = 1'b1; end
            SHA: begin
                sh = int'($signed(op2));
                if (sh >= 16)       r.result = 16'h0000;
                else if (sh >= 0)   r.result = rd << sh;
                else if (sh <= -16) r.result = rd[15] ? 16'hFFFF : 16'h0000;
                else                r.result = $unsigned($signed(rd) >>> (-sh));
                r.wb = 1'b1;
            end
            MUL: begin
                prod = {16'd0, rd} * {16'd0, op2};
                r.result = prod[15:0];
                r.wb = 1'b1;
            end
            LDR: begin r.result = op2; r.wb = 1'b1; r.mrd = 1'b1; end
            STR: begin r.result = op2; r.store = rd; r.mwr = 1'b1; end
            default: ;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b1 && bus.valid_out === 1'b1) begin
            act = {bus.pc_out, bus.op_out, bus.dest_out, bus.result_out, bus.store_data_out,
                   bus.wb_en_out, bus.mem_rd_out, bus.mem_wr_out};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got record %h, required no valid_out", act);
            end else begin
                e = sb.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL sb_record: got %h, required %h", act, e);
                end
            end
        end
    end

    task automatic drive(input logic [4:0] op, input logic [1:0] cc, input logic [15:0] rd,
                         input logic [15:0] op2, input logic [3:0] dest);
        bus.pc_in     = next_pc;
        bus.op_cc_in  = {op, cc};
        bus.rd_val_in = rd;
        bus.op2_in    = op2;
        bus.dest_in   = dest;
        bus.valid_in  = 1'b1;
        sb.push_back(model(op, rd, op2, next_pc, dest));
        next_pc = next_pc + 16'd1;
    endtask

    // Drives one instruction and returns 1ns after the edge that accepted it.
    task automatic issue(input logic [4:0] op, input logic [1:0] cc, input logic [15:0] rd,
                         input logic [15:0] op2, input logic [3:0] dest);
        logic st;
        int n;
        drive(op, cc, rd, op2, dest);
        n = 0;
        do begin
            st = bus.stall_out;
            @(posedge clk);
            #1;
            n++;
        end while (st && n < 20);
        checks++;
        if (st) begin
            errors++;
            $display("FAIL issue_timeout: stall_out=%b after %0d cycles, required 0", st, n);
        end
    endtask

    task automatic idle();
        bus.valid_in = 1'b0;
    endtask

    task automatic test_reset();
        logic [81:0] outs;
        reset = 1'b0;
        bus.pc_in = '0; bus.op_cc_in = '0; bus.rd_val_in = '0;
        bus.op2_in = '0; bus.dest_in = '0; bus.valid_in = 1'b0;
        #2;
        outs = {bus.pc_out, bus.op_out, bus.dest_out, bus.result_out, bus.store_data_out,
                bus.valid_out, bus.wb_en_out, bus.mem_rd_out, bus.mem_wr_out,
                bus.z_out, bus.halt_out, bus.stall_out};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", outs);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_alu();
        issue(ADD, S, 16'h0003, 16'h0005, 4'd1);
        checks++;
        if (bus.result_out !== 16'h0008 || bus.wb_en_out !== 1'b1 || bus.z_out !== 1'b0) begin
            errors++;
            $display("FAIL add_s: got res=%h wb=%b z=%b, required 0008 1 0",
                     bus.result_out, bus.wb_en_out, bus.z_out);
        end
        issue(SUB, S, 16'h0005, 16'h0005, 4'd2);
        checks++;
        if (bus.result_out !== 16'h0000 || bus.z_out !== 1'b1) begin
            errors++;
            $display("FAIL sub_zero: got res=%h z=%b, required 0000 1", bus.result_out, bus.z_out);
        end
        issue(AND_, AL, 16'h0003, 16'h0001, 4'd3);
        checks++;
        if (bus.result_out !== 16'h0001 || bus.z_out !== 1'b1) begin
            errors++;
            $display("FAIL and_al_holds_z: got res=%h z=%b, required 0001 1", bus.result_out, bus.z_out);
        end
        issue(SLT, AL, 16'hFFFF, 16'h0001, 4'd4);
        issue(SLT, AL, 16'h7FFF, 16'h8000, 4'd4);
        issue(NEG, AL, 16'h0000, 16'h0001, 4'd4);
        issue(ADD, S, 16'hFFFF, 16'h0002, 4'd5);
        // LDR and STR with a zero address under cc=S must not touch Z.
        issue(LDR, S, 16'h0000, 16'h0000, 4'd6);
        issue(STR, S, 16'h0000, 16'h0000, 4'd6);
        checks++;
        if (bus.z_out !== 1'b0) begin
            errors++;
            $display("FAIL ldr_str_keep_z: got z=%b, required 0", bus.z_out);
        end
        for (int i = 0; i < 24; i++)
            issue(5'($urandom_range(0, 8)), 2'(2 * $urandom_range(0, 1) + ($urandom_range(0, 1) * 3 % 3 == 0 ? 0 : 0)),
                  16'($urandom), 16'($urandom), 4'($urandom));
        idle();
    endtask

    task automatic test_sha();
        issue(SHA, AL, 16'h8000, 16'hFFFC, 4'd1);
        checks++;
        if (bus.result_out !== 16'hF800) begin
            errors++;
            $display("FAIL sha_right_arith: got %h, required F800", bus.result_out);
        end
        issue(SHA, AL, 16'h0001, 16'h000F, 4'd1);
        checks++;
        if (bus.result_out !== 16'h8000) begin
            errors++;
            $display("FAIL sha_left15: got %h, required 8000", bus.result_out);
        end
        issue(SHA, AL, 16'h0001, 16'h0010, 4'd1);
        checks++;
        if (bus.result_out !== 16'h0000) begin
            errors++;
            $display("FAIL sha_left16: got %h, required 0000", bus.result_out);
        end
        issue(SHA, AL, 16'h8001, 16'hFFF0, 4'd1);
        checks++;
        if (bus.result_out !== 16'hFFFF) begin
            errors++;
            $display("FAIL sha_right16: got %h, required FFFF", bus.result_out);
        end
        issue(SHA, AL, 16'h4000, 16'h8000, 4'd1);
        for (int i = 0; i < 16; i++)
            issue(SHA, AL, 16'($urandom), 16'($signed($urandom_range(0, 40)) - 20), 4'd2);
        idle();
    endtask

    task automatic test_mem();
        issue(STR, AL, 16'hBEEF, 16'h0040, 4'd7);
        checks++;
        if (bus.mem_wr_out !== 1'b1 || bus.store_data_out !== 16'hBEEF ||
            bus.result_out !== 16'h0040 || bus.wb_en_out !== 1'b0) begin
            errors++;
            $display("FAIL str: got wr=%b sd=%h res=%h wb=%b, required 1 BEEF 0040 0",
                     bus.mem_wr_out, bus.store_data_out, bus.result_out, bus.wb_en_out);
        end
        issue(LDR, AL, 16'h1234, 16'h0040, 4'd8);
        checks++;
        if (bus.mem_rd_out !== 1'b1 || bus.wb_en_out !== 1'b1 || bus.mem_wr_out !== 1'b0) begin
            errors++;
            $display("FAIL ldr: got rd=%b wb=%b wr=%b, required 1 1 0",
                     bus.mem_rd_out, bus.wb_en_out, bus.mem_wr_out);
        end
        idle();
    endtask

    task automatic test_misc();
        logic z0;
        logic [4:0] ops [6];
        ops = '{NOP, 5'b11010, 5'b10101, 5'b10111, ADDF, RECF};
        z0 = bus.z_out;
        foreach (ops[i]) issue(ops[i], S, 16'h1111, 16'h2222, 4'd9);
        checks++;
        if (bus.valid_out !== 1'b1 || bus.result_out !== 16'h0000 || bus.z_out !== z0) begin
            errors++;
            $display("FAIL misc_noop: got v=%b res=%h z=%b, required 1 0000 %b",
                     bus.valid_out, bus.result_out, bus.z_out, z0);
        end
        idle();
    endtask

    task automatic test_mul();
        int n;
        issue(MUL, S, 16'h0012, 16'h0034, 4'd3);
        checks++;
        if (bus.stall_out !== 1'b1 || bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL mul_accept: got stall=%b v=%b, required 1 0", bus.stall_out, bus.valid_out);
        end
        drive(ADD, AL, 16'h0100, 16'h0001, 4'd5);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.stall_out !== 1'b1 || bus.valid_out !== 1'b0) begin
                errors++;
                $display("FAIL mul_busy_e%0d: got stall=%b v=%b, required 1 0",
                         i, bus.stall_out, bus.valid_out);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.stall_out !== 1'b0 || bus.valid_out !== 1'b1 ||
            bus.result_out !== 16'h03A8 || bus.z_out !== 1'b0) begin
            errors++;
            $display("FAIL mul_done: got stall=%b v=%b res=%h z=%b, required 0 1 03A8 0",
                     bus.stall_out, bus.valid_out, bus.result_out, bus.z_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.valid_out !== 1'b1 || bus.op_out !== ADD || bus.result_out !== 16'h0101) begin
            errors++;
            $display("FAIL mul_held_next: got v=%b op=%h res=%h, required 1 00 0101",
                     bus.valid_out, bus.op_out, bus.result_out);
        end
        idle();
        issue(MUL, S, 16'h0100, 16'h0100, 4'd1);
        idle();
        n = 0;
        while (bus.valid_out !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (bus.valid_out !== 1'b1 || bus.result_out !== 16'h0000 || bus.z_out !== 1'b1) begin
            errors++;
            $display("FAIL mul_zero_z: got v=%b res=%h z=%b, required 1 0000 1",
                     bus.valid_out, bus.result_out, bus.z_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] op;
        for (int i = 0; i < 30; i++) begin
            op = 5'($urandom_range(0, 13));
            issue(op, (($urandom_range(0, 1)) != 0) ? 2'd2 : AL, 16'($urandom), 16'($urandom), 4'($urandom));
        end
        idle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_busy_halt();
        logic [81:0] outs;
        issue(MUL, AL, 16'h00FF, 16'h00FF, 4'd2);
        idle();
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        sb.delete();
        #1;
        outs = {bus.pc_out, bus.op_out, bus.dest_out, bus.result_out, bus.store_data_out,
                bus.valid_out, bus.wb_en_out, bus.mem_rd_out, bus.mem_wr_out,
                bus.z_out, bus.halt_out, bus.stall_out};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_in_busy: got %h, required 0", outs);
        end
        @(negedge clk);
        reset = 1'b1;
        issue(SYS, AL, 16'h0000, 16'h0000, 4'd0);
        checks++;
        if (bus.halt_out !== 1'b1 || bus.valid_out !== 1'b1) begin
            errors++;
            $display("FAIL sys_halt: got halt=%b v=%b, required 1 1", bus.halt_out, bus.valid_out);
        end
        bus.op_cc_in = {ADD, AL};
        bus.valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.valid_out !== 1'b0 || bus.halt_out !== 1'b1) begin
                errors++;
                $display("FAIL halted_ignores_%0d: got v=%b halt=%b, required 0 1",
                         i, bus.valid_out, bus.halt_out);
            end
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu();
        test_sha();
        test_mem();
        test_misc();
        test_mul();
        test_back_to_back();
        test_reset_busy_halt();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending records, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stage2_execute.md
STAGE2_EXECUTE -- requirements
Module: stage2_execute

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-003 SHALL have port pc_in  in  16  PC of incoming instruction, from decode stage.
REQ-004 SHALL have port op_cc_in  in  7  {opcode[6:2], cc[1:0]} from decode stage.
REQ-005 SHALL have port rd_val_in  in  16  value of register Rd.
REQ-006 SHALL have port op2_in  in  16  resolved operand 2 (immediate/PRE-extended or register).
REQ-007 SHALL have port dest_in  in  4  Rd register index.
REQ-008 SHALL have port valid_in  in  1  input holds a real instruction.
REQ-009 SHALL have port stall_out  out  1  upstream holds all inputs while 1.
REQ-010 SHALL have ports pc_out 16, op_out 5, dest_out 4, result_out 16, store_data_out 16  out  registered to writeback/memory stage.
REQ-011 SHALL have ports valid_out, wb_en_out, mem_rd_out, mem_wr_out, z_out, halt_out  out  1 each.

Function
REQ-012 SHALL accept an instruction on a rising edge where valid_in=1, stall_out=0, halt_out=0; otherwise the next edge drives a bubble (valid_out=0, wb_en/mem_rd/mem_wr=0).
REQ-013 SHALL, for accepted non-MUL instructions, present outputs on the edge of acceptance (1-cycle latency), pc_out/op_out/dest_out copied from inputs.
REQ-014 SHALL compute result_out mod 2^16: ADD rd+op2; SUB rd-op2; AND rd&op2; BIC rd&~op2; EOR rd^op2; ORR rd|op2; MOV op2; NEG -op2; SLT (signed rd < signed op2)?1:0.
REQ-015 SHALL compute SHA as rd shifted by signed op2: op2>=0 left logical, op2<0 right arithmetic by -op2; magnitude >=16 yields 0 (left) or 16 copies of rd[15] (right).
REQ-016 SHALL assert wb_en_out=1 for ADD, SUB, AND, BIC, EOR, ORR, MOV, NEG, SLT, SHA, MUL, LDR.
REQ-017 SHALL for LDR drive result_out=op2 (address), mem_rd_out=1; for STR drive result_out=op2, store_data_out=rd_val_in, mem_wr_out=1, wb_en_out=0.
REQ-018 SHALL treat NOP, PRE (opcode 11xxx), unused 10101-10111 and float ops (ADDF, SUBF, MULF, ITOF, FTOI, RECF) as valid_out=1 with result_out=0 and no enables.
REQ-019 SHALL implement MUL as iterative 4-bit-per-step shift-add, low 16 bits of rd*op2, two-state FSM IDLE/BUSY with 2-bit step counter.
REQ-020 SHALL on MUL acceptance (IDLE) latch operands, enter BUSY with count=0, drive a bubble; stall_out = (state==BUSY), combinational.
REQ-021 SHALL in BUSY increment count each edge; on the edge where count==3, write MUL result with valid_out=1, return to IDLE; the held input is not consumed on that edge.
REQ-022 SHALL update z_out <= (result==0) only when cc==S (1) and instruction sets wb_en and is not LDR; MUL updates Z at its completion edge; otherwise z_out holds.
REQ-023 SHALL on accepting SYS drive valid_out=1, set halt_out=1 sticky until reset, and accept nothing thereafter.
REQ-024 SHALL not filter on cc NE/EQ (squashing is done upstream); cc AL and S both execute.

Reset
REQ-025 SHALL, while reset=0, clear all outputs to 0, FSM to IDLE, count to 0, latched MUL operands to 0, aborting any MUL in progress.
REQ-026 SHALL resume accepting on the first rising edge after reset returns to 1.

Verification
REQ-027 ADD cc=S rd=0x0003 op2=0x0005 -> next edge result_out=0x0008, wb_en=1, z_out=0.
REQ-028 SUB cc=S rd=0x0005 op2=0x0005 -> result_out=0x0000, z_out=1; following AND cc=AL result 0x0001 -> z_out stays 1.
REQ-029 MUL rd=0x0012 op2=0x0034 accepted at edge E0 -> stall_out=1 cycles E0-E4, bubbles at E1-E3, result_out=0x03A8 valid at E4, held next instruction accepted at E5.
REQ-030 SHA rd=0x8000 op2=0xFFFC -> 0xF800; rd=0x0001 op2=0x000F -> 0x8000; op2=0x0010 -> 0x0000.
REQ-031 STR rd=0xBEEF op2=0x0040 -> mem_wr=1, store_data_out=0xBEEF, result_out=0x0040, wb_en=0; LDR op2=0x0040 -> mem_rd=1, wb_en=1.
REQ-032 reset=0 asserted during BUSY count=2 -> all outputs 0 immediately, stall_out=0; SYS afterwards -> halt_out=1 and later valid_in ignored.
